// File: rtl/mac_pkg.sv
// Shared helpers for the MAC tree: level-count math, config check and the
// saturation-direction tests used by the accumulator stage.
package mac_pkg;

  localparam int MAX_W = 64;

  typedef enum logic [1:0] {SAT_NONE, SAT_HI, SAT_LO} sat_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int tree_levels(input int tree_size);
    return clog2(tree_size);
  endfunction

  function automatic int root_w(input int data_w, input int tree_size);
    return 2 * data_w + tree_levels(tree_size);
  endfunction

  // The root sum must fit the accumulator, and the widened sum must fit MAX_W.
  function automatic bit cfg_ok(input int data_w, input int tree_size, input int acc_w);
    return (tree_size >= 2) && ((1 << tree_levels(tree_size)) == tree_size) &&
           (acc_w >= root_w(data_w, tree_size)) && (acc_w + 1 <= MAX_W);
  endfunction

  function automatic sat_e sat_signed(input logic signed [MAX_W-1:0] v, input int w);
    logic signed [MAX_W-1:0] hi;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    if (v > hi) return SAT_HI;
    if (v < -hi - 64'sd1) return SAT_LO;
    return SAT_NONE;
  endfunction

  function automatic sat_e sat_unsigned(input logic [MAX_W-1:0] v, input int w);
    logic [MAX_W-1:0] hi;
    hi = (64'd1 << w) - 64'd1;
    return (v > hi) ? SAT_HI : SAT_NONE;
  endfunction

endpackage

// File: rtl/mac_add_level.sv
// One registered adder-tree level: N operands of W bits -> N/2 sums of W+1 bits,
// carrying valid/last alongside and holding everything while en is low.
module mac_add_level #(
  parameter int N      = 2,
  parameter int W      = 16,
  parameter int SIGNED = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  d_vld,
  input  logic                  d_last,
  input  logic [N-1:0][W-1:0]   d,
  output logic                  q_vld,
  output logic                  q_last,
  output logic [N/2-1:0][W:0]   q
);

  logic [N/2-1:0][W:0] sum;

  for (genvar j = 0; j < N/2; j++) begin : g_pair
    logic [W:0] a, b;
    assign a      = {(SIGNED != 0) && d[2*j][W-1], d[2*j]};
    assign b      = {(SIGNED != 0) && d[2*j+1][W-1], d[2*j+1]};
    assign sum[j] = a + b;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      q_vld  <= 1'b0;
      q_last <= 1'b0;
      q      <= '0;
    end else if (en) begin
      q_vld  <= d_vld;
      q_last <= d_last;
      q      <= sum;
    end
  end

endmodule

// File: rtl/mac_tree_acc.sv
// Handshaked multiply / adder-tree / saturating accumulate pipeline.
// One global enable stalls every stage while the output is held.
module mac_tree_acc
  import mac_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int TREE_SIZE = 16,
  parameter int ACC_W     = 32,
  parameter int SIGNED    = 1
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [DATA_W*TREE_SIZE-1:0] in,
  input  logic [DATA_W*TREE_SIZE-1:0] kernal,
  input  logic                        in_valid,
  input  logic                        in_last,
  output logic                        in_ready,
  output logic [ACC_W-1:0]            out,
  output logic                        out_ovf,
  output logic                        out_valid,
  input  logic                        out_ready
);

  localparam int TREE_LEVELS = tree_levels(TREE_SIZE);
  localparam int PROD_W      = 2 * DATA_W;
  localparam int ROOT_W      = root_w(DATA_W, TREE_SIZE);
  localparam logic [ACC_W-1:0] S_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] S_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic [ACC_W-1:0] U_MAX = '1;

  if (!cfg_ok(DATA_W, TREE_SIZE, ACC_W)) begin : g_bad_cfg
    $error("mac_tree_acc: illegal TREE_SIZE/ACC_W configuration");
  end

  logic adv;
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv;

  // Stage M: operands widened to PROD_W so the low product bits are exact.
  logic [TREE_SIZE-1:0][PROD_W-1:0] prod_d, prod_q;
  logic                             m_vld, m_last;

  for (genvar i = 0; i < TREE_SIZE; i++) begin : g_mul
    logic [DATA_W-1:0] x, k;
    logic [PROD_W-1:0] a, b;
    assign x         = in[DATA_W*i +: DATA_W];
    assign k         = kernal[DATA_W*i +: DATA_W];
    assign a         = {{DATA_W{(SIGNED != 0) && x[DATA_W-1]}}, x};
    assign b         = {{DATA_W{(SIGNED != 0) && k[DATA_W-1]}}, k};
    assign prod_d[i] = a * b;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_vld  <= 1'b0;
      m_last <= 1'b0;
      prod_q <= '0;
    end else if (adv) begin
      m_vld  <= in_valid;
      m_last <= in_last;
      prod_q <= prod_d;
    end
  end

  // Stages T1..TL: each level reads the previous level's registered outputs.
  for (genvar l = 0; l < TREE_LEVELS; l++) begin : g_lvl
    localparam int N = TREE_SIZE >> l;
    localparam int W = PROD_W + l;
    logic [N-1:0][W-1:0]   d;
    logic [N/2-1:0][W:0]   q;
    logic                  dv, dl, qv, ql;

    if (l == 0) begin : g_src
      assign d  = prod_q;
      assign dv = m_vld;
      assign dl = m_last;
    end else begin : g_src
      assign d  = g_lvl[l-1].q;
      assign dv = g_lvl[l-1].qv;
      assign dl = g_lvl[l-1].ql;
    end

    mac_add_level #(.N(N), .W(W), .SIGNED(SIGNED)) u_add (
      .clock (clock),
      .reset (reset),
      .en    (adv),
      .d_vld (dv),
      .d_last(dl),
      .d     (d),
      .q_vld (qv),
      .q_last(ql),
      .q     (q)
    );
  end

  logic [ROOT_W-1:0] root;
  logic              root_vld, root_last;
  assign root      = g_lvl[TREE_LEVELS-1].q[0];
  assign root_vld  = g_lvl[TREE_LEVELS-1].qv;
  assign root_last = g_lvl[TREE_LEVELS-1].ql;

  // Stage A: one guard bit above ACC_W so the add itself never wraps.
  logic [ACC_W-1:0] acc, clamped;
  logic [ACC_W:0]   base, tree_ext, sum;
  logic             sticky, base_sticky, fresh, a_vld, a_last, ovf;
  sat_e             sdir;

  always_comb begin
    base        = fresh ? '0 : {(SIGNED != 0) && acc[ACC_W-1], acc};
    base_sticky = fresh ? 1'b0 : sticky;
    tree_ext    = {{(ACC_W+1-ROOT_W){(SIGNED != 0) && root[ROOT_W-1]}}, root};
    sum         = base + tree_ext;
    sdir        = (SIGNED != 0) ? sat_signed(MAX_W'($signed(sum)), ACC_W)
                                : sat_unsigned(MAX_W'(sum), ACC_W);
    clamped     = sum[ACC_W-1:0];
    if (sdir == SAT_HI)      clamped = (SIGNED != 0) ? S_MAX : U_MAX;
    else if (sdir == SAT_LO) clamped = S_MIN;
    ovf         = (sdir != SAT_NONE);
  end

  // fresh marks that the next valid beat opens a job, so bubbles between jobs
  // cannot resurrect the previous job's total.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      acc    <= '0;
      sticky <= 1'b0;
      fresh  <= 1'b1;
      a_vld  <= 1'b0;
      a_last <= 1'b0;
    end else if (adv) begin
      a_vld  <= root_vld;
      a_last <= root_last;
      if (root_vld) begin
        acc    <= clamped;
        sticky <= base_sticky | ovf;
        fresh  <= root_last;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out       <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else if (adv) begin
      out_valid <= a_vld && a_last;
      if (a_vld && a_last) begin
        out     <= acc;
        out_ovf <= sticky;
      end
    end
  end

endmodule

// File: tb/tb_mac_tree_acc.sv
// Directed bench for mac_tree_acc: three configurations, scoreboard per DUT.
module tb_mac_tree_acc;

  typedef struct { logic [31:0] v; logic ovf; } exp_t;

  logic         clk, rst_n;
  logic [127:0] in_v [3];
  logic [127:0] kr_v [3];
  logic [2:0]   iv, il, ordy;
  logic [2:0]   irdy, ov, oovf;
  logic [31:0]  o0, o1;
  logic [19:0]  o2;
  exp_t         q0[$], q1[$], q2[$];
  int           n_tests = 0;
  int           n_fail  = 0;

  mac_tree_acc #(.DATA_W(8), .TREE_SIZE(16), .ACC_W(32), .SIGNED(0)) u0 (
    .clock(clk), .reset(rst_n), .in(in_v[0]), .kernal(kr_v[0]), .in_valid(iv[0]),
    .in_last(il[0]), .in_ready(irdy[0]), .out(o0), .out_ovf(oovf[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]));

  mac_tree_acc #(.DATA_W(8), .TREE_SIZE(16), .ACC_W(32), .SIGNED(1)) u1 (
    .clock(clk), .reset(rst_n), .in(in_v[1]), .kernal(kr_v[1]), .in_valid(iv[1]),
    .in_last(il[1]), .in_ready(irdy[1]), .out(o1), .out_ovf(oovf[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]));

  mac_tree_acc #(.DATA_W(8), .TREE_SIZE(16), .ACC_W(20), .SIGNED(0)) u2 (
    .clock(clk), .reset(rst_n), .in(in_v[2]), .kernal(kr_v[2]), .in_valid(iv[2]),
    .in_last(il[2]), .in_ready(irdy[2]), .out(o2), .out_ovf(oovf[2]),
    .out_valid(ov[2]), .out_ready(ordy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic logic [127:0] rep(input logic [7:0] x);
    return {16{x}};
  endfunction

  function automatic logic [127:0] lane0(input logic [7:0] x);
    return {120'b0, x};
  endfunction

  task automatic push(input int d, input logic [31:0] v, input logic f);
    exp_t e;
    e.v = v;
    e.ovf = f;
    case (d)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Called at a negedge; returns at the negedge right after the beat is taken.
  task automatic beat(input int d, input logic [127:0] a, input logic [127:0] b, input logic last);
    int n;
    n = 0;
    in_v[d] = a;
    kr_v[d] = b;
    il[d]   = last;
    iv[d]   = 1'b1;
    while (!irdy[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("accept_u%0d", d), 32'(irdy[d]), 32'd1);
    @(negedge clk);
    iv[d] = 1'b0;
    il[d] = 1'b0;
  endtask

  task automatic wait_ov(input int d, input int max);
    int n;
    n = 0;
    while (!ov[d] && n < max) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("out_valid_arrive_u%0d", d), 32'(ov[d]), 32'd1);
  endtask

  // Scoreboard: sample just before the rising edge where a handshake lands.
  always begin
    @(negedge clk);
    #4;
    if (rst_n) begin
      for (int d = 0; d < 3; d++) begin
        if (ov[d] && ordy[d]) begin : mon
          exp_t        e;
          int          sz;
          logic [31:0] got;
          got = (d == 0) ? o0 : (d == 1) ? o1 : {12'b0, o2};
          sz  = (d == 0) ? q0.size() : (d == 1) ? q1.size() : q2.size();
          check($sformatf("result_pending_u%0d", d), 32'(sz > 0), 32'd1);
          if (sz > 0) begin
            case (d)
              0:       e = q0.pop_front();
              1:       e = q1.pop_front();
              default: e = q2.pop_front();
            endcase
            check($sformatf("out_u%0d", d), got, e.v);
            check($sformatf("ovf_u%0d", d), 32'(oovf[d]), 32'(e.ovf));
          end
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1;
    iv    = '0;
    il    = '0;
    ordy  = '1;
    for (int d = 0; d < 3; d++) begin
      in_v[d] = '0;
      kr_v[d] = '0;
    end
    #2 rst_n = 1'b0;
    #2;
    check("rst_out_valid", 32'(ov), 32'd0);
    check("rst_out_u0", o0, 32'd0);
    check("rst_out_ovf", 32'(oovf), 32'd0);
    check("rst_in_ready", 32'(irdy), 32'h7);
    @(negedge clk);
    rst_n = 1'b1;

    // Single beat of ones: 16 after exactly 6 cycles.
    push(0, 32'd16, 1'b0);
    beat(0, rep(8'h01), rep(8'h01), 1'b1);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      check($sformatf("latency_cyc%0d", k), 32'(ov[0]), 32'(k == 6));
    end

    // Signed: -1 * 2 over 16 lanes.
    push(1, 32'hFFFF_FFE0, 1'b0);
    beat(1, rep(8'hFF), rep(8'h02), 1'b1);
    repeat (8) @(negedge clk);

    // Three-beat job then a one-beat job, back to back.
    beat(0, lane0(8'd10), lane0(8'd1), 1'b0);
    beat(0, lane0(8'd20), lane0(8'd1), 1'b0);
    push(0, 32'd60, 1'b0);
    beat(0, lane0(8'd30), lane0(8'd1), 1'b1);
    push(0, 32'd5, 1'b0);
    beat(0, lane0(8'd5), lane0(8'd1), 1'b1);
    wait_ov(0, 20);
    @(negedge clk);
    check("b2b_second_valid", 32'(ov[0]), 32'd1);
    @(negedge clk);
    check("b2b_then_idle", 32'(ov[0]), 32'd0);

    // Bubbles inside a job leave the running sum alone.
    beat(0, lane0(8'd7), lane0(8'd1), 1'b0);
    repeat (2) @(negedge clk);
    push(0, 32'd15, 1'b0);
    beat(0, lane0(8'd8), lane0(8'd1), 1'b1);
    repeat (8) @(negedge clk);

    // Backpressure: result 96 held 4 cycles, 16 queued behind it.
    ordy[0] = 1'b0;
    push(0, 32'd96, 1'b0);
    beat(0, rep(8'd2), rep(8'd3), 1'b1);
    push(0, 32'd16, 1'b0);
    beat(0, rep(8'd1), rep(8'd1), 1'b1);
    wait_ov(0, 20);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("stall_in_ready_%0d", k), 32'(irdy[0]), 32'd0);
      check($sformatf("stall_out_%0d", k), o0, 32'd96);
      check($sformatf("stall_valid_%0d", k), 32'(ov[0]), 32'd1);
      @(negedge clk);
    end
    ordy[0] = 1'b1;
    repeat (4) @(negedge clk);

    // Unsigned ACC_W=20 saturation, then a clean job.
    push(2, 32'h000F_FFFF, 1'b1);
    beat(2, rep(8'hFF), rep(8'hFF), 1'b0);
    beat(2, rep(8'hFF), rep(8'hFF), 1'b1);
    push(2, 32'd16, 1'b0);
    beat(2, rep(8'h01), rep(8'h01), 1'b1);
    repeat (12) @(negedge clk);

    // Reset in the middle of a job: no output, no residue afterwards.
    beat(0, rep(8'h01), rep(8'h01), 1'b0);
    beat(0, rep(8'h01), rep(8'h01), 1'b0);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", 32'(ov[0]), 32'd0);
    check("midrst_out", o0, 32'd0);
    check("midrst_in_ready", 32'(irdy[0]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    push(0, 32'd48, 1'b0);
    beat(0, rep(8'd3), rep(8'd1), 1'b1);
    repeat (12) @(negedge clk);

    check("sb_empty_u0", 32'(q0.size()), 32'd0);
    check("sb_empty_u1", 32'(q1.size()), 32'd0);
    check("sb_empty_u2", 32'(q2.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mac_tree_acc.md
# mac_tree_acc

Parametrised, handshaked multiply-accumulate tree for the convolution datapath. Each beat is TREE_SIZE input/kernel operand pairs. Each beat is multiplied, reduced through a registered adder tree and accumulated across beats until a beat marked last. The saturated sum is then emitted on a valid/ready output port. It generalises the fixed 8-bit/32-bit product-sum tree with:

- selectable signedness
- multi-beat kernel folding
- backpressure
- overflow reporting

## Interface
Parameters:
- DATA_W, 8, operand width of each input and kernel element
- TREE_SIZE, 16, operand pairs per beat; power of two, at least 2
- ACC_W, 32, accumulator/output width; must be at least 2*DATA_W + log2(TREE_SIZE)
- SIGNED, 1, 1 = two's-complement operands and result, 0 = unsigned

Ports:
- clock  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- in  in  DATA_W*TREE_SIZE  operand vector, element i at [DATA_W*(i+1)-1 : DATA_W*i]
- kernal  in  DATA_W*TREE_SIZE  kernel vector, same packing
- in_valid  in  1  beat present
- in_last  in  1  beat closes the current accumulation job
- in_ready  out  1  beat accepted when in_valid && in_ready
- out  out  ACC_W  accumulated, saturated job result
- out_ovf  out  1  saturation occurred at any point during this job
- out_valid  out  1  result present
- out_ready  in  1  downstream accepts result

## Operation
- **Stage M (multiply):** TREE_SIZE products of 2*DATA_W bits, registered. Products are sign-extended if SIGNED, zero-extended otherwise.
- **Stages T1..TL (adder tree):** L = log2(TREE_SIZE). Each level adds adjacent pairs and grows 1 bit. The root is 2*DATA_W+L bits and cannot overflow.
- **Stage A (accumulate):** tree sum extended to ACC_W+1 bits and added to the accumulator.
  - The result is clamped to the ACC_W range: signed [-2^(ACC_W-1), 2^(ACC_W-1)-1] or unsigned [0, 2^ACC_W-1].
  - A clamp sets a sticky job-overflow bit.
  - The first beat of a job adds to zero, not to the stale accumulator.
- **Job end:** a beat carrying last at stage A does the following:
  - loads out/out_ovf with the final clamped sum and sticky bit;
  - sets out_valid;
  - clears the accumulator and sticky bit for the next job.
- **Sideband:** valid and last travel through all stages as sidebands. Bubbles (valid=0) do not touch the accumulator.
- **Stall:** global pipeline enable `adv = !out_valid || out_ready`; in_ready = adv.
  - When adv = 0, every stage, sideband, accumulator and output register holds.
  - out stays stable while out_valid && !out_ready.
- **Back-to-back jobs:** a last beat is followed directly by the next job's first beat. No idle cycle is required; the next job starts from zero.
- **Reset (asserted, asynchronous):**
  - clears all valids, sidebands, the accumulator, the sticky bit, out=0, out_ovf=0 and out_valid=0;
  - a job in flight is discarded with no partial output;
  - in_ready = 1 after reset.

## Timing
- Latency from acceptance of a last beat to out_valid is L+2 cycles with no stall (TREE_SIZE=16 gives 6).
- Throughput is one beat per cycle. One result per job is produced, and it appears the cycle after its last beat leaves stage A.
- Stall cycles add 1:1 to latency.
- in_ready is combinational from out_valid and out_ready only, never from in_valid.
- Downstream acceptance: the result is consumed on the edge where out_valid && out_ready.
  - If a new last beat reaches stage A on the same edge, the output register reloads and out_valid stays 1.
  - Otherwise out_valid drops.
- A single-beat job (first = last) is legal.

## Structure
- Shared package mac_pkg holds:
  - a clog2 function;
  - derived constants TREE_LEVELS and ROOT_W = 2*DATA_W+TREE_LEVELS;
  - sat-clamp helper functions (signed and unsigned);
  - the elaboration check that ACC_W >= ROOT_W.
- One sub-module, mac_add_level: a parametrised registered level that reduces N operands of width W into N/2 operands of width W+1, with enable and sideband valid/last. It is instantiated L times by a generate loop.

## Test plan
- TREE_SIZE=16, SIGNED=0, one last beat, all in=1, kernal=1 -> out=16, out_ovf=0, out_valid exactly 6 cycles after acceptance.
- SIGNED=1, all in=0xFF (-1), kernal=0x02, single beat -> out=-32 (0xFFFFFFE0), out_ovf=0.
- Three-beat job, per-beat products sum to 10, 20, 30, followed immediately by a one-beat job summing to 5 -> outputs 60 then 5, consecutive cycles, no idle beat.
- out_ready held low 4 cycles while out_valid -> in_ready=0 and out stable for all 4 cycles; the pipeline resumes with no lost or duplicated result.
- ACC_W=20, SIGNED=0, two beats of all 0xFF×0xFF (1,040,400 each) -> out=0xFFFFF, out_ovf=1; the next job clean at 16 gives out_ovf=0.
- Reset asserted mid-way through a three-beat job -> out_valid=0 and out=0 immediately; the next single-beat job after release gives the correct fresh sum, with no residue.
